// File: rtl/button_conditioner_pkg.sv
// Purpose : shared definitions for the button front end and the selector stage it feeds.
// Latency : n/a (types, constants and a width helper only).
// Backpr. : n/a.
// Contents: FSM state encoding, sel encoding, counter-width helper.
package button_conditioner_pkg;

  // FSM state encoding
  localparam logic [2:0] S_IDLE         = 3'd0;
  localparam logic [2:0] S_PRESS_WAIT   = 3'd1;
  localparam logic [2:0] S_PRESSED      = 3'd2;
  localparam logic [2:0] S_LONG_HELD    = 3'd3;
  localparam logic [2:0] S_RELEASE_WAIT = 3'd4;

  typedef enum logic [2:0] {
    IDLE         = S_IDLE,
    PRESS_WAIT   = S_PRESS_WAIT,
    PRESSED      = S_PRESSED,
    LONG_HELD    = S_LONG_HELD,
    RELEASE_WAIT = S_RELEASE_WAIT
  } state_t;

  // Mode select encoding, shared with the selector stage
  localparam logic SEL_DICE   = 1'b0;
  localparam logic SEL_LIGHTS = 1'b1;

  // Bits needed to hold a count of 0..n-1 (at least one bit)
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/button_conditioner_sync.sv
// Purpose : two-flop synchroniser for asynchronous inputs (d -> s1 -> q).
// Latency : 2 clk edges from d to q.
// Backpr. : none; free-running sampler.
// Ports   : clk, rst (sync, active high), d (async in), q (synchronised out).
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] s1;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      q  <= '0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Purpose : synchronise + debounce a push button; emit level, press/release/long pulses, sel toggle.
// Latency : press/release accepted DEBOUNCE_CYCLES+2 edges after first raw sample; long LONG_CYCLES after press.
// Backpr. : none; outputs are registered pulses/levels, consumer must sample every cycle.
// Ports   : clk, rst (sync, active high), button_raw (async bouncy, 1 = pressed),
//           btn_level, btn_press, btn_release, btn_long (1-cycle pulses), sel (0 = dice, 1 = lights).
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int LONG_CYCLES     = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic button_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_long,
  output logic sel
);

  localparam int DW = cnt_width(DEBOUNCE_CYCLES);
  localparam int HW = cnt_width(LONG_CYCLES);
  localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HMAX = HW'(LONG_CYCLES - 1);
  localparam logic [DW-1:0] DONE = DW'(1);
  localparam logic [HW-1:0] HONE = HW'(1);

  logic          s2;
  state_t        state, state_nx;
  logic [DW-1:0] dcnt, dcnt_nx;
  logic [HW-1:0] hcnt, hcnt_nx;
  logic          long_done, long_done_nx;
  logic          level_nx, press_nx, release_nx, long_nx, sel_nx;

  sync_2ff #(.WIDTH(1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (button_raw),
    .q   (s2)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      dcnt        <= '0;
      hcnt        <= '0;
      long_done   <= 1'b0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      btn_long    <= 1'b0;
      sel         <= SEL_DICE;
    end else begin
      state       <= state_nx;
      dcnt        <= dcnt_nx;
      hcnt        <= hcnt_nx;
      long_done   <= long_done_nx;
      btn_level   <= level_nx;
      btn_press   <= press_nx;
      btn_release <= release_nx;
      btn_long    <= long_nx;
      sel         <= sel_nx;
    end
  end

  // Counters only increment on branches where they are below their
  // terminal value, so they saturate rather than wrap.
  always_comb begin
    state_nx     = state;
    dcnt_nx      = dcnt;
    hcnt_nx      = hcnt;
    long_done_nx = long_done;
    press_nx     = 1'b0;
    release_nx   = 1'b0;
    long_nx      = 1'b0;
    sel_nx       = sel;

    case (state)
      IDLE: begin
        if (s2) begin
          state_nx = PRESS_WAIT;
          dcnt_nx  = DONE;
        end
      end

      PRESS_WAIT: begin
        if (!s2) begin
          state_nx = IDLE;
          dcnt_nx  = '0;
        end else if (dcnt == DMAX) begin
          state_nx     = PRESSED;
          press_nx     = 1'b1;
          hcnt_nx      = '0;
          dcnt_nx      = '0;
          long_done_nx = 1'b0;
        end else begin
          dcnt_nx = dcnt + DONE;
        end
      end

      // Release takes priority over the long threshold in the same cycle.
      PRESSED: begin
        if (!s2) begin
          state_nx = RELEASE_WAIT;
          dcnt_nx  = DONE;
        end else if (hcnt == HMAX) begin
          state_nx     = LONG_HELD;
          long_nx      = 1'b1;
          sel_nx       = ~sel;
          long_done_nx = 1'b1;
        end else begin
          hcnt_nx = hcnt + HONE;
        end
      end

      LONG_HELD: begin
        if (!s2) begin
          state_nx = RELEASE_WAIT;
          dcnt_nx  = DONE;
        end
      end

      // A bounce returns to whichever held state we left; hcnt was frozen
      // here so the long-press timing resumes where it stopped.
      RELEASE_WAIT: begin
        if (s2) begin
          state_nx = long_done ? LONG_HELD : PRESSED;
          dcnt_nx  = '0;
        end else if (dcnt == DMAX) begin
          state_nx   = IDLE;
          release_nx = 1'b1;
          dcnt_nx    = '0;
        end else begin
          dcnt_nx = dcnt + DONE;
        end
      end

      default: begin
        state_nx = IDLE;
        dcnt_nx  = '0;
      end
    endcase

    // Level follows the next state so it moves on the same edge as the pulses.
    level_nx = (state_nx == PRESSED) || (state_nx == LONG_HELD) ||
               (state_nx == RELEASE_WAIT);
  end

endmodule

// File: tb/tb_button_conditioner.sv
module tb_button_conditioner;

  localparam int DEB  = 4;
  localparam int LNG  = 10;
  localparam int NVEC = 28;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic button_raw = 1'b0;
  logic btn_level, btn_press, btn_release, btn_long, sel;

  int   passed = 0;
  int   total  = 0;
  logic exp_sel = 1'b0;

  typedef struct {
    logic       rst;
    logic       raw;
    logic [4:0] exp;  // {level, press, release, long, sel}
  } vec_t;

  vec_t vecs [NVEC];

  button_conditioner #(
    .DEBOUNCE_CYCLES (DEB),
    .LONG_CYCLES     (LNG)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .button_raw  (button_raw),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .btn_long    (btn_long),
    .sel         (sel)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [4:0] exp);
    logic [4:0] act;
    act = {btn_level, btn_press, btn_release, btn_long, sel};
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b want %b (level,press,release,long,sel)", name, act, exp);
  endtask

  // Raw held high for 'hold' edges starting from an idle, debounced-low state.
  // Press accepted at edge DEB+2, long pulse LNG edges later.
  task automatic hold_phase(input int hold, input string name);
    logic lvl, prs, lng;
    button_raw = 1'b1;
    for (int e = 1; e <= hold; e++) begin
      tick();
      lvl = (e >= DEB + 2);
      prs = (e == DEB + 2);
      lng = (e == DEB + 2 + LNG);
      if (lng) exp_sel = ~exp_sel;
      check($sformatf("%s_hold_e%0d", name, e), {lvl, prs, 1'b0, lng, exp_sel});
    end
  endtask

  // Raw low from an accepted-press state; release lands DEB+2 edges later.
  task automatic release_phase(input string name);
    button_raw = 1'b0;
    for (int f = 1; f <= DEB + 4; f++) begin
      tick();
      check($sformatf("%s_rel_f%0d", name, f),
            {(f < DEB + 2), 1'b0, (f == DEB + 2), 1'b0, exp_sel});
    end
  endtask

  initial begin
    // Vector i = inputs before edge i, expected outputs after it.
    // v0-1 reset; v2.. clean press (edge 1 = v2, press at v7);
    // release bounce raw 0,0,1 at v9-11 then 0 (final fall before v12, release at v17);
    // glitch: raw high v20-22 only, never accepted.
    for (int i = 0; i < NVEC; i++) begin
      vecs[i].rst = (i < 2);
      vecs[i].raw = ((i >= 2) && (i <= 8)) || (i == 11) || ((i >= 20) && (i <= 22));
      vecs[i].exp = 5'b00000;
      if (i == 7) vecs[i].exp = 5'b11000;
      if ((i >= 8) && (i <= 16)) vecs[i].exp = 5'b10000;
      if (i == 17) vecs[i].exp = 5'b00100;
    end

    for (int i = 0; i < NVEC; i++) begin
      rst        = vecs[i].rst;
      button_raw = vecs[i].raw;
      tick();
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // First long press: sel 0 -> 1
    hold_phase(20, "long1");
    release_phase("long1");
    // Second long press: sel 1 -> 0
    hold_phase(20, "long2");
    release_phase("long2");
    // Short press: sel unchanged
    hold_phase(8, "short");
    release_phase("short");
    // s2 falls exactly on the edge where hcnt reaches LNG-1: no long pulse
    hold_phase(DEB + LNG - 1, "thresh");
    release_phase("thresh");
    // Set sel to 1 so reset visibly clears it
    hold_phase(20, "long3");
    release_phase("long3");

    // Reset while pressed with raw held; then full re-debounce
    hold_phase(8, "pre_rst");
    rst = 1'b1;
    tick();
    exp_sel = 1'b0;
    check("rst_mid", 5'b00000);
    rst = 1'b0;
    hold_phase(8, "post_rst");
    release_phase("post_rst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
